// File: rtl/xa_bf_ddr_rd_sched_pkg.sv
// Shared encodings for the DDR3 read scheduler: FSM states, job types and
// completion status codes.
package xa_bf_sched_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_WAIT  = 4'b0100,
    ST_RESP  = 4'b1000
  } sched_state_e;

  typedef enum logic [1:0] {
    JOB_PARAM = 2'b00,
    JOB_RAM0  = 2'b01,
    JOB_RAM1  = 2'b10,
    JOB_RSVD  = 2'b11
  } job_type_e;

  typedef enum logic {
    STAT_OK      = 1'b0,
    STAT_TIMEOUT = 1'b1
  } job_status_e;

  localparam logic [15:0] TMO_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/xa_bf_ddr_rd_sched_rr_pick.sv
// Combinational round-robin picker: first set pend bit at or above the
// pointer, wrapping around the channel count.
module xa_bf_rr_pick
  import xa_bf_sched_pkg::*;
#(
  parameter int P_REQ_NUM = 4,
  localparam int IW = $clog2(P_REQ_NUM)
) (
  input  logic [P_REQ_NUM-1:0] pend_i,
  input  logic [IW-1:0]        ptr_i,
  output logic                 found_o,
  output logic [IW-1:0]        id_o
);

  logic [IW-1:0] idx;

  // P_REQ_NUM is a power of two, so the IW-bit sum wraps for free
  always_comb begin
    found_o = 1'b0;
    id_o    = '0;
    idx     = '0;
    for (int i = 0; i < P_REQ_NUM; i++) begin
      idx = ptr_i + IW'(i);
      if (!found_o && pend_i[idx]) begin
        found_o = 1'b1;
        id_o    = idx;
      end
    end
  end

endmodule

// File: rtl/xa_bf_ddr_rd_sched.sv
// Round-robin scheduler sharing the DDR3 read engine among beam-forming
// control channels; one job in flight, completion or timeout per channel.
module xa_bf_ddr_rd_sched
  import xa_bf_sched_pkg::*;
#(
  parameter int          P_REQ_NUM = 4,
  parameter logic [15:0] P_TIMEOUT = 16'd50000,
  localparam int IW = $clog2(P_REQ_NUM)
) (
  input  logic                   i_clk156m,
  input  logic                   i_srst,
  input  logic [P_REQ_NUM-1:0]   i_req,
  input  logic [2*P_REQ_NUM-1:0] i_req_type,
  input  logic [P_REQ_NUM-1:0]   i_cancel,
  output logic                   o_ddr_start,
  output logic [IW-1:0]          o_ddr_id,
  output logic [1:0]             o_ddr_type,
  input  logic                   i_ddr_done,
  output logic [P_REQ_NUM-1:0]   o_done,
  output logic [P_REQ_NUM-1:0]   o_timeout,
  output logic [P_REQ_NUM-1:0]   o_pend,
  output logic                   o_busy
);

  sched_state_e                state_q;
  logic [P_REQ_NUM-1:0]        pend_q, pend_d, new_req;
  logic [P_REQ_NUM-1:0][1:0]   type_q;
  logic [IW-1:0]               rr_ptr_q, id_q, pick_id;
  logic [1:0]                  ddr_type_q;
  logic                        start_q, busy_q, cancel_q, pick_found;
  logic [P_REQ_NUM-1:0]        done_q, tmo_q;
  logic [15:0]                 cnt_q;
  logic                        tmo_hit, wait_exit, grant_cancel;
  job_status_e                 wait_stat;

  xa_bf_rr_pick #(.P_REQ_NUM(P_REQ_NUM)) u_pick (
    .pend_i  (pend_q & ~i_cancel),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .id_o    (pick_id)
  );

  assign tmo_hit      = (cnt_q == P_TIMEOUT - 16'd1);
  assign wait_exit    = i_ddr_done || tmo_hit;
  assign wait_stat    = i_ddr_done ? STAT_OK : STAT_TIMEOUT;
  assign grant_cancel = cancel_q || i_cancel[id_q];

  // Cancel beats a same-cycle request; a cancelled grant already lost its pend bit
  always_comb begin
    new_req = '0;
    for (int n = 0; n < P_REQ_NUM; n++) begin
      new_req[n] = i_req[n] && !pend_q[n] &&
                   (i_req_type[2*n +: 2] != JOB_RSVD);
    end
    pend_d = (pend_q | new_req) & ~i_cancel;
    if (state_q == ST_RESP && !cancel_q) pend_d[id_q] = 1'b0;
  end

  always_ff @(posedge i_clk156m) begin
    if (i_srst) begin
      state_q    <= ST_IDLE;
      pend_q     <= '0;
      type_q     <= '0;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      ddr_type_q <= 2'b00;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      cancel_q   <= 1'b0;
      done_q     <= '0;
      tmo_q      <= '0;
      cnt_q      <= '0;
    end else begin
      pend_q  <= pend_d;
      start_q <= 1'b0;
      done_q  <= '0;
      tmo_q   <= '0;
      for (int n = 0; n < P_REQ_NUM; n++) begin
        if (new_req[n] && !i_cancel[n]) type_q[n] <= i_req_type[2*n +: 2];
      end
      case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            id_q       <= pick_id;
            ddr_type_q <= type_q[pick_id];
            start_q    <= 1'b1;
            busy_q     <= 1'b1;
            cancel_q   <= 1'b0;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_q <= '0;
          if (i_cancel[id_q]) cancel_q <= 1'b1;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_q != TMO_CNT_MAX) cnt_q <= cnt_q + 16'd1;
          if (i_cancel[id_q]) cancel_q <= 1'b1;
          // Pulse lands in the RESP cycle; done wins over a simultaneous timeout
          if (wait_exit) begin
            state_q <= ST_RESP;
            if (!grant_cancel) begin
              if (wait_stat == STAT_OK) done_q[id_q] <= 1'b1;
              else                      tmo_q[id_q]  <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          rr_ptr_q <= id_q + IW'(1);
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ddr_start = start_q;
  assign o_ddr_id    = id_q;
  assign o_ddr_type  = ddr_type_q;
  assign o_done      = done_q;
  assign o_timeout   = tmo_q;
  assign o_pend      = pend_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_xa_bf_ddr_rd_sched.sv
// Scoreboard bench for xa_bf_ddr_rd_sched: stimulus pushes expected start and
// completion events with their edge numbers; a negedge monitor pops and checks.
module tb_xa_bf_ddr_rd_sched;

  localparam int EV_START   = 0;
  localparam int EV_DONE    = 1;
  localparam int EV_TIMEOUT = 2;

  typedef struct {
    int kind;
    int id;
    int typ;
    int edgeExp;
  } ev_t;

  logic       i_clk156m = 1'b0;
  logic       i_srst = 1'b1;
  logic [3:0] i_req = '0;
  logic [7:0] i_req_type = '0;
  logic [3:0] i_cancel = '0;
  logic       i_ddr_done = 1'b0;
  logic       o_ddr_start;
  logic [1:0] o_ddr_id;
  logic [1:0] o_ddr_type;
  logic [3:0] o_done, o_timeout, o_pend;
  logic       o_busy;

  int  checks = 0;
  int  errors = 0;
  int  edgeCnt = 0;
  ev_t evQ[$];

  xa_bf_ddr_rd_sched #(.P_REQ_NUM(4), .P_TIMEOUT(16'd20)) dut (
    .i_clk156m  (i_clk156m),
    .i_srst     (i_srst),
    .i_req      (i_req),
    .i_req_type (i_req_type),
    .i_cancel   (i_cancel),
    .o_ddr_start(o_ddr_start),
    .o_ddr_id   (o_ddr_id),
    .o_ddr_type (o_ddr_type),
    .i_ddr_done (i_ddr_done),
    .o_done     (o_done),
    .o_timeout  (o_timeout),
    .o_pend     (o_pend),
    .o_busy     (o_busy)
  );

  always #5 i_clk156m = ~i_clk156m;
  always @(posedge i_clk156m) edgeCnt <= edgeCnt + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edgeCnt);
    end
  endtask

  task automatic pushEv(input int kind, input int id, input int typ, input int edgeExp);
    ev_t e;
    e.kind = kind; e.id = id; e.typ = typ; e.edgeExp = edgeExp;
    evQ.push_back(e);
  endtask

  function automatic int typeOf(input logic [7:0] tv, input int id);
    return int'(tv[2*id +: 2]);
  endfunction

  task automatic tick();
    @(posedge i_clk156m);
    #1;
  endtask

  task automatic waitUntil(input int target);
    while (edgeCnt < target) tick();
  endtask

  // Drives one cycle of inputs, sampled at the next edge, then returns them to idle
  task automatic applyStimulus(input logic [3:0] req, input logic [7:0] typ,
                               input logic [3:0] cancel, input logic done);
    i_req = req; i_req_type = typ; i_cancel = cancel; i_ddr_done = done;
    tick();
    i_req = '0; i_req_type = '0; i_cancel = '0; i_ddr_done = 1'b0;
  endtask

  // Requests several channels at once and completes each grant d cycles after its start
  task automatic runBatch(input logic [3:0] reqMask, input logic [7:0] reqType,
                          input int n, input int order[4], input int d);
    int s;
    s = edgeCnt + 2;
    pushEv(EV_START, order[0], typeOf(reqType, order[0]), s);
    applyStimulus(reqMask, reqType, 4'b0, 1'b0);
    for (int g = 0; g < n; g++) begin
      waitUntil(s + d);
      pushEv(EV_DONE, order[g], 0, s + d + 1);
      if (g < n - 1) pushEv(EV_START, order[g+1], typeOf(reqType, order[g+1]), s + d + 3);
      applyStimulus(4'b0, 8'b0, 4'b0, 1'b1);
      s = s + d + 3;
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_start"},   int'(o_ddr_start), 0);
    checkOutput({tag, "_id"},      int'(o_ddr_id), 0);
    checkOutput({tag, "_type"},    int'(o_ddr_type), 0);
    checkOutput({tag, "_done"},    int'(o_done), 0);
    checkOutput({tag, "_timeout"}, int'(o_timeout), 0);
    checkOutput({tag, "_pend"},    int'(o_pend), 0);
    checkOutput({tag, "_busy"},    int'(o_busy), 0);
  endtask

  // Monitor: every start or completion pulse must match the head of the scoreboard
  always @(negedge i_clk156m) begin
    ev_t e;
    if (o_ddr_start) begin
      if (evQ.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_start: got id %0d at edge %0d, expected no event", o_ddr_id, edgeCnt);
      end else begin
        e = evQ.pop_front();
        checkOutput("ev_kind_start", EV_START, e.kind);
        checkOutput("start_id", int'(o_ddr_id), e.id);
        checkOutput("start_type", int'(o_ddr_type), e.typ);
        checkOutput("start_edge", edgeCnt, e.edgeExp);
      end
    end
    if (o_done != 0 || o_timeout != 0) begin
      if (evQ.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_resp: got done %b timeout %b at edge %0d, expected no event", o_done, o_timeout, edgeCnt);
      end else begin
        e = evQ.pop_front();
        checkOutput("ev_kind_resp", (o_done != 0) ? EV_DONE : EV_TIMEOUT, e.kind);
        checkOutput("done_vec", int'(o_done), (e.kind == EV_DONE) ? (1 << e.id) : 0);
        checkOutput("timeout_vec", int'(o_timeout), (e.kind == EV_TIMEOUT) ? (1 << e.id) : 0);
        checkOutput("resp_edge", edgeCnt, e.edgeExp);
      end
    end
  end

  initial begin
    #60000;
    $display("[TB] FAIL watchdog: got no end of test by time %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    int s2;
    tick(); tick(); tick();
    i_srst = 1'b0;
    checkIdleOutputs("reset");

    // Single job on channel 2, type RAM0
    s = edgeCnt + 2;
    pushEv(EV_START, 2, 1, s);
    applyStimulus(4'b0100, 8'b00_01_00_00, 4'b0, 1'b0);
    checkOutput("single_pend", int'(o_pend), 4'b0100);
    checkOutput("single_busy_early", int'(o_busy), 0);
    waitUntil(s + 10);
    pushEv(EV_DONE, 2, 0, s + 11);
    applyStimulus(4'b0, 8'b0, 4'b0, 1'b1);
    waitUntil(s + 14);
    checkOutput("single_pend_after", int'(o_pend), 0);
    checkOutput("single_busy_after", int'(o_busy), 0);

    // Round-robin from a fresh pointer, then 0 ahead of 3
    i_srst = 1'b1; tick(); i_srst = 1'b0;
    runBatch(4'b1111, 8'b00_10_01_00, 4, '{0, 1, 2, 3}, 2);
    tick(); tick();
    runBatch(4'b1001, 8'b01_00_00_10, 2, '{0, 3, 0, 0}, 1);
    tick(); tick();

    // Timeout on channel 1 then a stray late done
    s = edgeCnt + 2;
    pushEv(EV_START, 1, 2, s);
    pushEv(EV_TIMEOUT, 1, 0, s + 21);
    applyStimulus(4'b0010, 8'b00_00_10_00, 4'b0, 1'b0);
    waitUntil(s + 25);
    applyStimulus(4'b0, 8'b0, 4'b0, 1'b1);
    waitUntil(s + 28);
    checkOutput("tmo_pend_after", int'(o_pend), 0);
    checkOutput("tmo_busy_after", int'(o_busy), 0);

    // Done in the same cycle as the timeout
    s = edgeCnt + 2;
    pushEv(EV_START, 3, 0, s);
    pushEv(EV_DONE, 3, 0, s + 21);
    applyStimulus(4'b1000, 8'b00_00_00_00, 4'b0, 1'b0);
    waitUntil(s + 20);
    applyStimulus(4'b0, 8'b0, 4'b0, 1'b1);
    waitUntil(s + 24);

    // Request and cancel together: nothing granted
    applyStimulus(4'b0001, 8'b00_00_00_01, 4'b0001, 1'b0);
    tick(); tick();
    checkOutput("reqcancel_pend", int'(o_pend), 0);
    checkOutput("reqcancel_busy", int'(o_busy), 0);

    // Cancel of granted channel 1 during WAIT; channel 2 follows
    s = edgeCnt + 2;
    pushEv(EV_START, 1, 1, s);
    applyStimulus(4'b0110, 8'b00_00_01_00, 4'b0, 1'b0);
    waitUntil(s + 3);
    applyStimulus(4'b0, 8'b0, 4'b0010, 1'b0);
    checkOutput("cancel_pend", int'(o_pend), 4'b0100);
    waitUntil(s + 6);
    s2 = s + 9;
    pushEv(EV_START, 2, 0, s2);
    applyStimulus(4'b0, 8'b0, 4'b0, 1'b1);
    waitUntil(s2 + 1);
    pushEv(EV_DONE, 2, 0, s2 + 2);
    applyStimulus(4'b0, 8'b0, 4'b0, 1'b1);
    waitUntil(s2 + 5);

    // Reserved type dropped, repeated request keeps its first type
    s = edgeCnt + 2;
    pushEv(EV_START, 1, 0, s);
    applyStimulus(4'b0010, 8'b00_00_00_00, 4'b0, 1'b0);
    applyStimulus(4'b1001, 8'b11_00_00_01, 4'b0, 1'b0);
    applyStimulus(4'b0001, 8'b00_00_00_10, 4'b0, 1'b0);
    checkOutput("repeat_pend", int'(o_pend), 4'b0011);
    waitUntil(s + 2);
    pushEv(EV_DONE, 1, 0, s + 3);
    pushEv(EV_START, 0, 1, s + 5);
    applyStimulus(4'b0, 8'b0, 4'b0, 1'b1);
    waitUntil(s + 6);
    pushEv(EV_DONE, 0, 0, s + 7);
    applyStimulus(4'b0, 8'b0, 4'b0, 1'b1);
    waitUntil(s + 10);

    // Synchronous reset during WAIT, then the pointer must restart at 0
    s = edgeCnt + 2;
    pushEv(EV_START, 2, 2, s);
    applyStimulus(4'b0100, 8'b00_10_00_00, 4'b0, 1'b0);
    waitUntil(s + 3);
    i_srst = 1'b1;
    tick();
    checkIdleOutputs("midreset");
    i_srst = 1'b0;
    applyStimulus(4'b0, 8'b0, 4'b0, 1'b1);
    tick();
    runBatch(4'b1001, 8'b01_00_00_10, 2, '{0, 3, 0, 0}, 1);
    tick(); tick(); tick();
    checkOutput("scoreboard_empty", evQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
